// File: rtl/acc_vec_engine.sv
// Byte-wise vector engine: applies one of four 8-bit operations to every byte of
// the A/B operand arrays, LANES words per clock, and reports busy/done/error.
module acc_vec_engine #(
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned LANES     = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                start,
    input  logic [1:0]          op_i,
    input  logic [3:0][7:0]     acc_in_A [NUM_WORDS],
    input  logic [3:0][7:0]     acc_in_B [NUM_WORDS],
    output logic [3:0][7:0]     acc_out  [NUM_WORDS],
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - LANES);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        op_q;
    logic              start_q;
    logic              trigger;

    assign trigger = start & ~start_q;

    // Four independent byte lanes; bytes never carry into each other.
    function automatic logic [3:0][7:0] word_op(input logic [1:0]      op,
                                                input logic [3:0][7:0] a,
                                                input logic [3:0][7:0] b);
        logic [3:0][7:0] r;
        logic [8:0]      sum;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            sum = {1'b0, a[j]} + {1'b0, b[j]};
            case (op)
                2'b00:   r[j] = sum[7:0];
                2'b01:   r[j] = a[j] - b[j];
                2'b10:   r[j] = 8'(a[j] * b[j]);
                default: r[j] = sum[8] ? 8'hFF : sum[7:0];
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            for (int w = 0; w < int'(NUM_WORDS); w++) begin
                acc_out[w] <= '0;
            end
        end else begin
            start_q <= start;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        op_q   <= op_i;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (trigger) begin
                        err_o <= 1'b1;
                    end
                    // Operands are sampled live; the wrapper holds them while busy.
                    for (int k = 0; k < int'(LANES); k++) begin
                        acc_out[idx + IDX_W'(k)] <= word_op(op_q,
                                                            acc_in_A[idx + IDX_W'(k)],
                                                            acc_in_B[idx + IDX_W'(k)]);
                    end
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + STEP;
                    end
                end
                DONE: begin
                    if (trigger) begin
                        err_o <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_vec_engine.sv
// Self-checking bench for acc_vec_engine: a default 256x4 instance and an 8x1
// instance, checked against a per-byte arithmetic reference model.
module tb_acc_vec_engine;

    localparam int unsigned NW  = 256;
    localparam int unsigned LN  = 4;
    localparam int unsigned NW2 = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start1, start2;
    logic [1:0]      op;
    logic [3:0][7:0] a1 [NW];
    logic [3:0][7:0] b1 [NW];
    logic [3:0][7:0] o1 [NW];
    logic [3:0][7:0] a2 [NW2];
    logic [3:0][7:0] b2 [NW2];
    logic [3:0][7:0] o2 [NW2];
    logic            busy1, done1, err1, busy2, done2, err2;
    logic [31:0]     exp1 [NW];
    logic [31:0]     exp2 [NW2];
    int              tests_run = 0;
    int              tests_failed = 0;

    always #5 clk = ~clk;

    acc_vec_engine #(.NUM_WORDS(NW), .LANES(LN)) dut_big (
        .clk(clk), .rst_i(rst), .start(start1), .op_i(op),
        .acc_in_A(a1), .acc_in_B(b1), .acc_out(o1),
        .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    acc_vec_engine #(.NUM_WORDS(NW2), .LANES(1)) dut_small (
        .clk(clk), .rst_i(rst), .start(start2), .op_i(op),
        .acc_in_A(a2), .acc_in_B(b2), .acc_out(o2),
        .busy_o(busy2), .done_o(done2), .err_o(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: each byte treated as an unsigned integer, result taken mod 256.
    function automatic logic [31:0] model_word(input logic [1:0] opv, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] res;
        int x, y, r;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            x = int'(a[j*8 +: 8]);
            y = int'(b[j*8 +: 8]);
            case (opv)
                2'd0:    r = (x + y) % 256;
                2'd1:    r = (x - y + 256) % 256;
                2'd2:    r = (x * y) % 256;
                default: r = (x + y > 255) ? 255 : x + y;
            endcase
            res[j*8 +: 8] = 8'(r);
        end
        return res;
    endfunction

    task automatic zero_models();
        for (int w = 0; w < int'(NW); w++) exp1[w] = '0;
        for (int w = 0; w < int'(NW2); w++) exp2[w] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        zero_models();
    endtask

    task automatic cmp_out(input int sel, input string tag);
        int nbad;
        int first;
        nbad  = 0;
        first = -1;
        if (sel == 0) begin
            for (int w = 0; w < int'(NW); w++)
                if (o1[w] !== exp1[w]) begin nbad++; if (first < 0) first = w; end
        end else begin
            for (int w = 0; w < int'(NW2); w++)
                if (o2[w] !== exp2[w]) begin nbad++; if (first < 0) first = w; end
        end
        check({tag, "_bad_words"}, 32'(nbad), 32'd0);
        if (first >= 0) $display("  first bad word index %0d", first);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v; else start2 = v;
    endtask

    // Launch a run and watch win cycles; op_i is scrambled after the trigger.
    task automatic run(input int sel, input logic [1:0] opv, input int start_len,
                       input int glitch_at, input int rst_at, input int win,
                       output int nbusy, output int ndone, output bit tim_ok);
        int last_busy;
        int done_at;
        logic b, d;
        last_busy = -1;
        done_at   = -1;
        nbusy     = 0;
        ndone     = 0;
        @(negedge clk);
        op = opv;
        set_start(sel, 1'b1);
        for (int i = 0; i < win; i++) begin
            @(negedge clk);
            b = (sel == 0) ? busy1 : busy2;
            d = (sel == 0) ? done1 : done2;
            if (b) begin nbusy++; last_busy = i; end
            if (d) begin ndone++; done_at = i; end
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("abort_busy", 32'(b), 32'd0);
                zero_models();
                cmp_out(sel, "abort_out");
            end
            if (i == 1) op = 2'($urandom);
            if (i == start_len - 1) set_start(sel, 1'b0);
            if (i == glitch_at) set_start(sel, 1'b1);
            if (i == glitch_at + 1) set_start(sel, 1'b0);
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 1) rst = 1'b0;
        end
        tim_ok = (ndone == 1) && (done_at == last_busy + 1);
        if (rst_at < 0) begin
            if (sel == 0) for (int w = 0; w < int'(NW); w++) exp1[w] = model_word(opv, a1[w], b1[w]);
            else          for (int w = 0; w < int'(NW2); w++) exp2[w] = model_word(opv, a2[w], b2[w]);
        end
    endtask

    task automatic full_run_big(input logic [1:0] opv, input string tag);
        int nb, nd;
        bit tok;
        run(0, opv, 1, -1, -1, 70, nb, nd, tok);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd64);
        check({tag, "_done_timing"}, 32'(tok), 32'd1);
        cmp_out(0, tag);
    endtask

    initial begin
        int nb, nd, nbusy2, ndone2;
        bit tok;
        op = 2'd0;
        for (int w = 0; w < int'(NW); w++) begin a1[w] = '0; b1[w] = '0; end
        for (int w = 0; w < int'(NW2); w++) begin a2[w] = '0; b2[w] = '0; end
        do_reset();

        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        cmp_out(0, "rst_out");

        for (int w = 0; w < int'(NW); w++) begin a1[w] = 32'h01020304; b1[w] = 32'h01020304; end
        full_run_big(2'd0, "add_basic");
        check("add_basic_word", o1[100], 32'h02040608);
        check("add_basic_err", 32'(err1), 32'd0);

        for (int w = 0; w < int'(NW); w++) begin a1[w] = 32'hF0F0F0F0; b1[w] = 32'h20202020; end
        full_run_big(2'd3, "sat");
        check("sat_word", o1[255], 32'hFFFFFFFF);
        full_run_big(2'd0, "add_wrap");
        check("add_wrap_word", o1[0], 32'h10101010);
        full_run_big(2'd1, "sub");
        check("sub_word", o1[7], 32'hD0D0D0D0);
        full_run_big(2'd2, "mul");
        check("mul_word", o1[64], 32'h00000000);

        for (int w = 0; w < int'(NW); w++) begin a1[w] = 32'h10FF0302; b1[w] = 32'h10FF0505; end
        full_run_big(2'd2, "mul_mix");
        check("mul_mix_word", o1[3], 32'h00010F0A);

        // Second start edge mid-run: ignored, flags error.
        for (int w = 0; w < int'(NW); w++) begin a1[w] = $urandom; b1[w] = $urandom; end
        run(0, 2'd3, 1, 10, -1, 70, nb, nd, tok);
        check("glitch_busy", 32'(nb), 32'd64);
        check("glitch_done_timing", 32'(tok), 32'd1);
        check("glitch_err", 32'(err1), 32'd1);
        cmp_out(0, "glitch");
        full_run_big(2'd1, "after_glitch");
        check("err_sticky", 32'(err1), 32'd1);

        // Level held high for 100 cycles produces exactly one run.
        do_reset();
        check("rst_err_clear", 32'(err1), 32'd0);
        run(0, 2'd0, 100, -1, -1, 110, nb, nd, tok);
        check("hold_busy", 32'(nb), 32'd64);
        check("hold_done_timing", 32'(tok), 32'd1);
        check("hold_err", 32'(err1), 32'd0);
        cmp_out(0, "hold");

        // Reset at run cycle 20 aborts with no completion pulse.
        for (int w = 0; w < int'(NW); w++) begin a1[w] = $urandom; b1[w] = $urandom; end
        run(0, 2'd2, 1, -1, 20, 70, nb, nd, tok);
        check("abort_done_count", 32'(nd), 32'd0);
        check("abort_busy_cycles", 32'(nb), 32'd21);
        full_run_big(2'd2, "post_abort");

        for (int t = 0; t < 5; t++) begin
            for (int w = 0; w < int'(NW); w++) begin a1[w] = $urandom; b1[w] = $urandom; end
            full_run_big(2'($urandom), "rand_big");
        end

        // Single-lane instance: ascending order, one word per cycle.
        do_reset();
        for (int w = 0; w < int'(NW2); w++) begin a2[w] = 32'(w); b2[w] = 32'd1; end
        nbusy2 = 0;
        ndone2 = 0;
        @(negedge clk);
        op = 2'd0;
        start2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy2) nbusy2++;
            if (done2) ndone2++;
            if (i >= 1 && i <= int'(NW2)) begin
                check("small_written", o2[i-1], model_word(2'd0, 32'(i-1), 32'd1));
                if (i < int'(NW2)) check("small_untouched", o2[i], 32'd0);
            end
            if (i == 0) start2 = 1'b0;
        end
        check("small_busy_cycles", 32'(nbusy2), 32'd8);
        check("small_done_count", 32'(ndone2), 32'd1);
        for (int w = 0; w < int'(NW2); w++) exp2[w] = model_word(2'd0, a2[w], b2[w]);
        cmp_out(1, "small_inc");

        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < int'(NW2); w++) begin a2[w] = $urandom; b2[w] = $urandom; end
            run(1, 2'(t), 1, -1, -1, 12, nb, nd, tok);
            check("small_rand_busy", 32'(nb), 32'd8);
            check("small_rand_timing", 32'(tok), 32'd1);
            cmp_out(1, "small_rand");
        end
        check("small_err", 32'(err2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
